// File: rtl/cms_pkg.sv
// Shared constants and word-layout helpers for the CMS trace packer.
// Optional feature macro: CMS_TIMESTAMP_EN (64-bit cycle stamp in each word).
package cms_pkg;

  localparam int XLEN                     = 64;
  localparam int NO_OF_PERFORMANCE_EVENTS = 37;
  localparam int CTR_WIDTH                = 8;
  localparam int CTRL_ADDR_WIDTH          = 8;
  localparam int CTRL_DATA_WIDTH          = 32;
  localparam int AXI_DATA_WIDTH           = 512;
  localparam int INSTR_WIDTH              = 32;
  localparam int TS_WIDTH                 = 64;

  // Bit offset of the instruction field: it sits directly above the PC.
  function automatic int instr_off(int xlen);
    return xlen;
  endfunction

  // Bit offset of event counter idx.
  function automatic int ctr_off(int xlen, int ctr_w, int idx);
    return xlen + INSTR_WIDTH + idx * ctr_w;
  endfunction

  // Bit offset of the timestamp: directly after the last event counter.
  function automatic int ts_off(int xlen, int n_ev, int ctr_w);
    return xlen + INSTR_WIDTH + n_ev * ctr_w;
  endfunction

endpackage

// File: rtl/cms_trace_packer_if.sv
// Stream read port between the packet buffer and the output bus.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready;
// while tvalid=1 and tready=0 the source holds tdata stable, and tvalid
// never depends on tready.
interface cms_trace_packer_if #(
  parameter int W = 512
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cms_sync_fifo.sv
// Synchronous first-word-fall-through buffer. The head word is presented on
// the read port as soon as it is written; a write into a full buffer is
// accepted when a read happens in the same cycle.
module cms_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  cms_trace_packer_if.master rd
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop, push;

  assign pop  = (count_q != '0) && rd.tready;
  assign push = push_i && ((count_q != DEPTH_V) || pop);

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the read data is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rd.tvalid = (count_q != '0);
  assign rd.tdata  = rd.tvalid ? mem_q[rd_ptr_q] : '0;
  assign full_o    = (count_q == DEPTH_V);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/cms_trace_packer.sv
// CMS trace packer: per-event saturating counters are packed together with
// each retired PC/instruction into one stream word, buffered, and sent out
// as a packetised stream with a programmable tlast interval.
// Optional feature macro: CMS_TIMESTAMP_EN adds a 64-bit cycle stamp field.
module cms_trace_packer #(
  parameter int XLEN                     = cms_pkg::XLEN,
  parameter int NO_OF_PERFORMANCE_EVENTS = cms_pkg::NO_OF_PERFORMANCE_EVENTS,
  parameter int CTR_WIDTH                = cms_pkg::CTR_WIDTH,
  parameter int AXI_DATA_WIDTH           = cms_pkg::AXI_DATA_WIDTH,
  parameter int FIFO_DEPTH               = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                pc_valid,
  input  logic [31:0]                         instr,
  input  logic [XLEN-1:0]                     pc,
  input  logic [NO_OF_PERFORMANCE_EVENTS-1:0] performance_events,
  output logic                                M_AXIS_tvalid,
  input  logic                                M_AXIS_tready,
  output logic [AXI_DATA_WIDTH-1:0]           M_AXIS_tdata,
  output logic                                M_AXIS_tlast,
  input  logic [31:0]                         tlast_interval,
  output logic [31:0]                         dropped_count
);
  import cms_pkg::*;

  localparam int N  = NO_OF_PERFORMANCE_EVENTS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(FIFO_DEPTH);
`ifdef CMS_TIMESTAMP_EN
  localparam int TS_BITS = TS_WIDTH;
`else
  localparam int TS_BITS = 0;
`endif
  localparam int USED_BITS = ts_off(XLEN, N, CTR_WIDTH) + TS_BITS;

  // Refuse to build a layout that does not fit in one stream word.
  if (USED_BITS > AXI_DATA_WIDTH) begin : g_layout_check
    $fatal(1, "cms_trace_packer: packed word does not fit in AXI_DATA_WIDTH");
  end

  logic [CTR_WIDTH-1:0]      ctr_q [N];
  logic [CTR_WIDTH-1:0]      ctr_d [N];
  logic [CTR_WIDTH-1:0]      ctr_sum [N];
  logic [AXI_DATA_WIDTH-1:0] word;
  logic [31:0]               dropped_q, dropped_d;
  logic [31:0]               beat_q, beat_d;
  logic                      fifo_full, fifo_empty;
  logic [AW:0]               fifo_count;
  logic                      push_try, push_ok, push_drop, pop;

  cms_trace_packer_if #(.W(AXI_DATA_WIDTH)) rd_if ();

  assign push_try  = en && pc_valid;
  assign pop       = M_AXIS_tvalid && M_AXIS_tready;
  assign push_ok   = push_try && ((fifo_count != DEPTH_V) || pop);
  assign push_drop = push_try && fifo_full && !pop;

  // Counter next-state: add this cycle's event, saturate, clear on accepted push.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctr_sum[i] = (ctr_q[i] == '1) ? ctr_q[i]
                                    : ctr_q[i] + CTR_WIDTH'(performance_events[i]);
      ctr_d[i]   = ctr_q[i];
      if (en) ctr_d[i] = push_ok ? '0 : ctr_sum[i];
    end
  end

  // Event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) ctr_q[i] <= ctr_d[i];
    end
  end

`ifdef CMS_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Free-running cycle stamp, wraps at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end
`endif

  // Assemble the outgoing word; counters include the current cycle's events.
  always_comb begin
    word = '0;
    word[XLEN-1:0] = pc;
    word[instr_off(XLEN) +: INSTR_WIDTH] = instr;
    for (int i = 0; i < N; i++) begin
      word[ctr_off(XLEN, CTR_WIDTH, i) +: CTR_WIDTH] = ctr_sum[i];
    end
`ifdef CMS_TIMESTAMP_EN
    word[ts_off(XLEN, N, CTR_WIDTH) +: TS_WIDTH] = ts_q;
`endif
  end

  cms_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .wdata_i (word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .rd      (rd_if.master)
  );

  assign rd_if.tready  = M_AXIS_tready;
  assign M_AXIS_tvalid = rd_if.tvalid;
  assign M_AXIS_tdata  = rd_if.tdata;

  // tlast compares against the live interval so a mid-packet change applies on the next beat.
  assign M_AXIS_tlast = !fifo_empty &&
                        ((tlast_interval <= 32'd1) || (beat_q >= tlast_interval - 32'd1));

  // Drop counter and beat counter next-state.
  always_comb begin
    dropped_d = dropped_q;
    beat_d    = beat_q;
    if (push_drop && (dropped_q != '1)) dropped_d = dropped_q + 32'd1;
    if (pop) beat_d = M_AXIS_tlast ? '0 : beat_q + 32'd1;
  end

  // Drop and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q <= '0;
      beat_q    <= '0;
    end else begin
      dropped_q <= dropped_d;
      beat_q    <= beat_d;
    end
  end

  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_cms_trace_packer.sv
// Directed bench for cms_trace_packer with default parameters.
module tb_cms_trace_packer;

  localparam int XLEN = 64;
  localparam int NEV  = 37;
  localparam int CW   = 8;
  localparam int DW   = 512;
  localparam int DEP  = 16;
  localparam int USED = XLEN + 32 + NEV * CW;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            pc_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [NEV-1:0]  ev;
  logic            tlast;
  logic [31:0]     interval;
  logic [31:0]     dropped;

  int checks;
  int failures;

  cms_trace_packer_if #(.W(DW)) axis ();

  cms_trace_packer #(
    .XLEN                     (XLEN),
    .NO_OF_PERFORMANCE_EVENTS (NEV),
    .CTR_WIDTH                (CW),
    .AXI_DATA_WIDTH           (DW),
    .FIFO_DEPTH               (DEP)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .pc_valid           (pc_valid),
    .instr              (instr),
    .pc                 (pc),
    .performance_events (ev),
    .M_AXIS_tvalid      (axis.tvalid),
    .M_AXIS_tready      (axis.tready),
    .M_AXIS_tdata       (axis.tdata),
    .M_AXIS_tlast       (tlast),
    .tlast_interval     (interval),
    .dropped_count      (dropped)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] ctr_of(input logic [DW-1:0] w, input int i);
    return w[XLEN + 32 + i * CW +: CW];
  endfunction

  function automatic logic [XLEN-1:0] pc_of(input logic [DW-1:0] w);
    return w[XLEN-1:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pc_valid = 1'b0; ev = '0;
    instr = '0; pc = '0; axis.tready = 1'b0; interval = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; pc_valid = 1'b0; ev = '0;
    instr = '0; pc = '0; axis.tready = 1'b0; interval = 32'd0;
    @(negedge clk);
    checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    checks++; if (axis.tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", axis.tdata); end
    checks++; if (dropped !== 32'd0) begin failures++; $display("FAIL reset_dropped got=%0d exp=0", dropped); end
    rst_n = 1'b1;
  endtask

  // Three pushes, interval 2: tlast 0,1,0 and matching pc/instr.
  task automatic test_basic();
    logic [2:0] exp_last;
    exp_last = 3'b010;
    do_reset();
    axis.tready = 1'b1; interval = 32'd2; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if (axis.tvalid !== 1'b1) begin failures++; $display("FAIL basic_tvalid beat=%0d got=%b exp=1", k-1, axis.tvalid); end
        checks++; if (pc_of(axis.tdata) !== 64'h1000 + 64'(k-1)) begin failures++; $display("FAIL basic_pc beat=%0d got=%h exp=%h", k-1, pc_of(axis.tdata), 64'h1000 + 64'(k-1)); end
        checks++; if (axis.tdata[95:64] !== 32'hA000_0000 + 32'(k-1)) begin failures++; $display("FAIL basic_instr beat=%0d got=%h", k-1, axis.tdata[95:64]); end
        checks++; if (tlast !== exp_last[k-1]) begin failures++; $display("FAIL basic_tlast beat=%0d got=%b exp=%b", k-1, tlast, exp_last[k-1]); end
      end
      if (k < 3) begin
        pc_valid = 1'b1; pc = 64'h1000 + 64'(k); instr = 32'hA000_0000 + 32'(k);
      end else begin
        pc_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%b exp=0", axis.tvalid); end
  endtask

  // Saturation, same-cycle event capture, clear-after-push and en freeze.
  task automatic test_events();
    logic others_zero;
    do_reset();
    axis.tready = 1'b1; en = 1'b1; pc_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ev = '0; ev[5] = 1'b1;
    end
    @(negedge clk);
    ev = '0; pc_valid = 1'b1; pc = 64'h5000;
    @(negedge clk);
    others_zero = 1'b1;
    for (int i = 0; i < NEV; i++) if (i != 5 && ctr_of(axis.tdata, i) !== '0) others_zero = 1'b0;
    checks++; if (ctr_of(axis.tdata, 5) !== 8'd255) begin failures++; $display("FAIL sat_ctr5 got=%0d exp=255", ctr_of(axis.tdata, 5)); end
    checks++; if (others_zero !== 1'b1) begin failures++; $display("FAIL sat_others got=%b exp=1", others_zero); end
    checks++; if (axis.tdata[DW-1:USED] !== '0) begin failures++; $display("FAIL upper_bits got=%h exp=0", axis.tdata[DW-1:USED]); end
    ev[3] = 1'b1; pc = 64'h5001;
    @(negedge clk);
    checks++; if (ctr_of(axis.tdata, 5) !== 8'd0) begin failures++; $display("FAIL clear_ctr5 got=%0d exp=0", ctr_of(axis.tdata, 5)); end
    checks++; if (ctr_of(axis.tdata, 3) !== 8'd1) begin failures++; $display("FAIL same_cycle_ctr3 got=%0d exp=1", ctr_of(axis.tdata, 3)); end
    pc_valid = 1'b0; ev = '0; ev[7] = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    @(negedge clk);
    en = 1'b0; pc_valid = 1'b1; pc = 64'h5002;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("FAIL en_blocks_push got=%b exp=0", axis.tvalid); end
    en = 1'b1; ev = '0;
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (pc_of(axis.tdata) !== 64'h5002) begin failures++; $display("FAIL freeze_pc got=%h exp=5002", pc_of(axis.tdata)); end
    checks++; if (ctr_of(axis.tdata, 7) !== 8'd4) begin failures++; $display("FAIL freeze_ctr7 got=%0d exp=4", ctr_of(axis.tdata, 7)); end
  endtask

  // DEPTH+3 pushes into a stalled stream: three drops, then DEPTH beats in order.
  task automatic test_drop();
    do_reset();
    axis.tready = 1'b0; en = 1'b1;
    for (int k = 0; k < DEP + 3; k++) begin
      @(negedge clk);
      pc_valid = 1'b1; pc = 64'h2000 + 64'(k);
    end
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (dropped !== 32'd3) begin failures++; $display("FAIL drop_count got=%0d exp=3", dropped); end
    checks++; if (pc_of(axis.tdata) !== 64'h2000) begin failures++; $display("FAIL drop_head got=%h exp=2000", pc_of(axis.tdata)); end
    @(negedge clk);
    checks++; if (pc_of(axis.tdata) !== 64'h2000 || axis.tvalid !== 1'b1) begin failures++; $display("FAIL stall_stable got=%h/%b exp=2000/1", pc_of(axis.tdata), axis.tvalid); end
    axis.tready = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      checks++; if (axis.tvalid !== 1'b1 || pc_of(axis.tdata) !== 64'h2000 + 64'(k)) begin failures++; $display("FAIL drain_order beat=%0d got=%h/%b exp=%h", k, pc_of(axis.tdata), axis.tvalid, 64'h2000 + 64'(k)); end
      @(negedge clk);
    end
    checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("FAIL drain_count got=%b exp=0", axis.tvalid); end
    checks++; if (dropped !== 32'd3) begin failures++; $display("FAIL drop_hold got=%0d exp=3", dropped); end
  endtask

  // Full buffer with a simultaneous push and pop: the push is accepted.
  task automatic test_full_push_pop();
    do_reset();
    axis.tready = 1'b0; en = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      @(negedge clk);
      pc_valid = 1'b1; pc = 64'h3000 + 64'(k);
    end
    @(negedge clk);
    pc = 64'h30FF; axis.tready = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    checks++; if (dropped !== 32'd0) begin failures++; $display("FAIL fullpp_dropped got=%0d exp=0", dropped); end
    for (int k = 1; k < DEP; k++) begin
      checks++; if (pc_of(axis.tdata) !== 64'h3000 + 64'(k)) begin failures++; $display("FAIL fullpp_order beat=%0d got=%h exp=%h", k, pc_of(axis.tdata), 64'h3000 + 64'(k)); end
      @(negedge clk);
    end
    checks++; if (axis.tvalid !== 1'b1 || pc_of(axis.tdata) !== 64'h30FF) begin failures++; $display("FAIL fullpp_new got=%h/%b exp=30ff/1", pc_of(axis.tdata), axis.tvalid); end
    @(negedge clk);
    checks++; if (axis.tvalid !== 1'b0) begin failures++; $display("FAIL fullpp_empty got=%b exp=0", axis.tvalid); end
  endtask

  // Asynchronous reset with a stalled word; counting restarts from zero.
  task automatic test_reset_flight();
    do_reset();
    axis.tready = 1'b0; en = 1'b1;
    ev = '0; ev[2] = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    pc_valid = 1'b1; pc = 64'h4000;
    @(negedge clk);
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++; if (axis.tvalid !== 1'b1) begin failures++; $display("FAIL flight_tvalid got=%b exp=1", axis.tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (axis.tvalid !== 1'b0 || tlast !== 1'b0 || axis.tdata !== '0) begin failures++; $display("FAIL async_reset got=%b/%b/%h exp=0/0/0", axis.tvalid, tlast, axis.tdata); end
    @(negedge clk);
    rst_n = 1'b1; pc_valid = 1'b1; pc = 64'h4001;
    @(negedge clk);
    pc_valid = 1'b0; ev = '0;
    checks++; if (pc_of(axis.tdata) !== 64'h4001 || axis.tvalid !== 1'b1) begin failures++; $display("FAIL post_reset_pc got=%h/%b exp=4001/1", pc_of(axis.tdata), axis.tvalid); end
    checks++; if (ctr_of(axis.tdata, 2) !== 8'd1) begin failures++; $display("FAIL post_reset_ctr2 got=%0d exp=1", ctr_of(axis.tdata, 2)); end
  endtask

  // tlast at intervals 0, 3, a mid-packet change 4->2, and 1.
  task automatic test_tlast_interval();
    int iv [10];
    bit el [10];
    iv = '{0, 0, 3, 3, 3, 4, 4, 2, 2, 1};
    el = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 1};
    do_reset();
    axis.tready = 1'b1; en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        interval = 32'(iv[k-1]);
        #1;
        checks++; if (tlast !== el[k-1]) begin failures++; $display("FAIL tlast_iv beat=%0d iv=%0d got=%b exp=%b", k-1, iv[k-1], tlast, el[k-1]); end
      end
      pc_valid = (k < 10); pc = 64'h6000 + 64'(k);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_events();
    test_drop();
    test_full_push_pop();
    test_reset_flight();
    test_tlast_interval();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cms_trace_packer.md
CMS_TRACE_PACKER -- requirements
Module: cms_trace_packer

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC width in bits.
REQ-002 SHALL have parameter NO_OF_PERFORMANCE_EVENTS, default 37, meaning the number of event inputs.
REQ-003 SHALL have parameter CTR_WIDTH, default 8, meaning the per-event saturating counter width.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 512, meaning the stream word width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16 (power of two, at least 2), meaning the packet buffer entries.
REQ-006 SHALL have port clk, input, width 1, the single clock.
REQ-007 SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-008 SHALL have ports en (in, 1, enable) and pc_valid (in, 1, the instr/pc pair retires this cycle).
REQ-009 SHALL have ports instr (in, 32) and pc (in, XLEN), the retired instruction and its PC.
REQ-010 SHALL have port performance_events, input, width NO_OF_PERFORMANCE_EVENTS, one-cycle event pulses.
REQ-011 SHALL have ports M_AXIS_tvalid (out, 1), M_AXIS_tready (in, 1), M_AXIS_tdata (out, AXI_DATA_WIDTH) and M_AXIS_tlast (out, 1).
REQ-012 SHALL have port tlast_interval, input, width 32, meaning beats per stream packet.
REQ-013 SHALL have port dropped_count, output, width 32, meaning packets lost to a full buffer.

Function
REQ-014 Word layout SHALL be [XLEN-1:0] pc, then 32 bits instr, then counter i at offset XLEN+32+i*CTR_WIDTH; unused upper bits SHALL be 0.
REQ-015 Elaboration SHALL fail if XLEN+32+NO_OF_PERFORMANCE_EVENTS*CTR_WIDTH (+64 with timestamp) exceeds AXI_DATA_WIDTH.
REQ-016 While en=1, each counter SHALL add its event bit every cycle and saturate at all-ones, never wrapping.
REQ-017 A push SHALL occur on a cycle where en=1, pc_valid=1 and the buffer can accept.
REQ-018 A pushed word SHALL contain the counters including the current cycle's events; the counters SHALL read 0 on the next cycle.
REQ-019 The buffer SHALL accept when occupancy<FIFO_DEPTH, or when full with a pop (tvalid and tready) in the same cycle.
REQ-020 A push attempt that is not accepted SHALL drop the packet, increment dropped_count (saturating at 2^32-1) and leave the counters uncleared.
REQ-021 First-word latency SHALL be 1 cycle: a push at cycle N gives tvalid=1 with that word at N+1.
REQ-022 M_AXIS_tvalid SHALL equal buffer non-empty, and tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-023 A beat counter SHALL count accepted beats; tlast=1 SHALL hold when beat_cnt >= tlast_interval-1, and the counter SHALL clear when a tlast beat is accepted.
REQ-024 tlast_interval of 0 or 1 SHALL assert tlast on every beat; a value change mid-packet SHALL take effect on the next compare.
REQ-025 en=0 SHALL block pushes and freeze the counters; buffered words SHALL still drain.

Reset
REQ-026 rst_n low SHALL immediately empty the buffer and force tvalid=0, tlast=0, tdata=0 and dropped_count=0.
REQ-027 rst_n low SHALL also clear all event counters and the beat counter, and SHALL discard any in-flight word.

Configuration
REQ-028 With CMS_TIMESTAMP_EN defined, a free-running 64-bit cycle counter (reset 0, wrapping) SHALL be sampled at push and placed directly after the last event counter.
REQ-029 Without CMS_TIMESTAMP_EN, no timestamp logic SHALL exist and those bits SHALL be 0.

Structure
REQ-030 cms_pkg SHALL hold XLEN, NO_OF_PERFORMANCE_EVENTS, CTRL_ADDR_WIDTH, CTRL_DATA_WIDTH, AXI_DATA_WIDTH and the layout offset constants/functions.
REQ-031 Buffering SHALL live in one sub-module, cms_sync_fifo (parametrised width/depth, first-word-fall-through, full/empty/count).

Verification
REQ-032 After reset, 3 pushes with tready=1 and tlast_interval=2 -> beats with tlast=0,1,0 and pc values matching the inputs.
REQ-033 Event 5 pulsed 300 times with CTR_WIDTH=8, then a push -> counter 5 field=255 and all other counters 0.
REQ-034 tready=0 with FIFO_DEPTH+3 pushes -> dropped_count=3; after releasing tready, exactly FIFO_DEPTH beats arrive in order.
REQ-035 Buffer full, with a push and a pop in the same cycle -> push accepted and dropped_count unchanged.
REQ-036 rst_n low while tvalid=1 and tready=0 -> tvalid=0 at once; after release, the next push has counters counted from 0.
